// File: rtl/mem_sp_vr.sv
// Single-port valid/ready memory slave (ROM or RAM) with 1-cycle read latency and a stall hold register.
// Define MEM_PARITY_EN to store one even-parity bit per byte and flag read mismatches on err_o.
module mem_sp_vr #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int DP        = 4096,
  parameter bit READ_ONLY = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   data_i,
  input  logic [DW/8-1:0] sel_i,
  input  logic            we_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  output logic [DW-1:0]   data_o,
  output logic            err_o,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i
);
  localparam int NB  = DW / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = AW - OFF;
  localparam int MW  = (DP > 1) ? $clog2(DP) : 1;

  if (!(DW == 32 || DW == 64)) begin : g_bad_dw
    $error("mem_sp_vr: DW must be 32 or 64");
  end
  if (DP < 2 || 64'(DP) > (64'd1 << IW)) begin : g_bad_dp
    $error("mem_sp_vr: DP out of range for AW/DW");
  end

  typedef enum logic [1:0] {IDLE, NEW, HOLD} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx;
  logic [MW-1:0] mem_addr;
  logic          in_range, accept, wr_en, rd_en, capture;
  logic          rsp_err_q, rsp_zero_q, rsp_rd_q;
  logic [DW-1:0] rd_q, new_data, hold_data_q;
  logic          new_err, hold_err_q, par_err;
  logic          addr_lsb_unused;

  assign idx             = addr_i[AW-1:OFF];
  assign addr_lsb_unused = ^addr_i[OFF-1:0];
  assign mem_addr        = idx[MW-1:0];
  assign in_range        = 64'(idx) < 64'(DP);

  assign rsp_valid_o = (state_q != IDLE);
  assign req_ready_o = !rsp_valid_o || rsp_ready_i;
  assign accept      = req_valid_i && req_ready_o;
  assign wr_en       = accept && we_i && in_range && !READ_ONLY;
  assign rd_en       = accept && !we_i && in_range;

  logic [DW-1:0] mem [DP];

  // NOTE: the array and its read register carry no reset; clearing a RAM costs a
  // write port per word and software never relies on its power-up contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (sel_i[b]) mem[mem_addr][8*b +: 8] <= data_i[8*b +: 8];
      end
    end
    if (rd_en) rd_q <= mem[mem_addr];
  end

`ifdef MEM_PARITY_EN
  logic [NB-1:0] par_mem [DP];
  logic [NB-1:0] rd_par_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (sel_i[b]) par_mem[mem_addr][b] <= ^data_i[8*b +: 8];
      end
    end
    if (rd_en) rd_par_q <= par_mem[mem_addr];
  end

  always_comb begin
    par_err = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if ((^rd_q[8*b +: 8]) != rd_par_q[b]) par_err = 1'b1;
    end
  end
`else
  assign par_err = 1'b0;
`endif

  // Writes, range errors and rejected writes all answer with zero data.
  assign new_data = rsp_zero_q ? '0 : rd_q;
  assign new_err  = rsp_err_q || (rsp_rd_q && par_err);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rsp_err_q   <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_rd_q    <= 1'b0;
      hold_data_q <= '0;
      hold_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rsp_rd_q   <= rd_en;
        rsp_zero_q <= !rd_en;
        rsp_err_q  <= !in_range || (we_i && (READ_ONLY || sel_i == '0));
      end
      if (capture) begin
        hold_data_q <= new_data;
        hold_err_q  <= new_err;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    data_o  = '0;
    err_o   = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = NEW;
      NEW: begin
        data_o = new_data;
        err_o  = new_err;
        if (rsp_ready_i) begin
          state_d = accept ? NEW : IDLE;
        end else begin
          state_d = HOLD;
          capture = 1'b1;
        end
      end
      HOLD: begin
        data_o = hold_data_q;
        err_o  = hold_err_q;
        if (rsp_ready_i) state_d = accept ? NEW : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_sp_vr.sv
// Self-checking bench for mem_sp_vr: directed scenarios plus a randomized run against a word-array model.
module tb_mem_sp_vr;
  localparam int DP = 12;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          cyc;
  } rsp_t;

  logic        clk, rst_n;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  logic        we, req_valid, rsp_ready;
  logic        req_ready, rsp_valid, err;
  logic [31:0] rdata;
  logic        ro_ready_unused, ro_valid, ro_err;
  logic [31:0] ro_data;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic acc;
  logic seen_valid, seen_err, seen_req_ready;
  logic [31:0] seen_data;
  rsp_t obs[$];
  rsp_t obs_ro[$];
  rsp_t exp_q[$];
  logic [31:0] ref_mem [DP];

  mem_sp_vr #(.AW(32), .DW(32), .DP(DP), .READ_ONLY(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .addr_i(addr), .data_i(wdata), .sel_i(sel), .we_i(we),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .data_o(rdata), .err_o(err),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready)
  );

  mem_sp_vr #(.AW(32), .DW(32), .DP(DP), .READ_ONLY(1'b1)) u_ro (
    .clk(clk), .rst_n(rst_n), .addr_i(addr), .data_i(wdata), .sel_i(sel), .we_i(we),
    .req_valid_i(req_valid), .req_ready_o(ro_ready_unused), .data_o(ro_data), .err_o(ro_err),
    .rsp_valid_o(ro_valid), .rsp_ready_i(rsp_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // One cycle: called at a negedge, drives the request, records what the DUT shows, ends at the next negedge.
  task automatic step(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic r, output logic accepted);
    rsp_t e;
    req_valid = v; we = w; addr = a; wdata = d; sel = s; rsp_ready = r;
    #1;
    seen_valid = rsp_valid; seen_data = rdata; seen_err = err; seen_req_ready = req_ready;
    if (rsp_valid && r) begin
      e.d = rdata; e.e = err; e.cyc = cyc;
      obs.push_back(e);
    end
    if (ro_valid && r) begin
      e.d = ro_data; e.e = ro_err; e.cyc = cyc;
      obs_ro.push_back(e);
    end
    accepted = v && req_ready;
    @(negedge clk);
    cyc++;
  endtask

  task automatic ref_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output rsp_t e);
    int unsigned i;
    i = a >> 2;
    e.d = '0; e.e = 1'b0; e.cyc = 0;
    if (i >= DP) begin
      e.e = 1'b1;
    end else if (w) begin
      e.e = (s == 4'h0);
      for (int b = 0; b < 4; b++) begin
        if (s[b]) ref_mem[i][8*b +: 8] = d[8*b +: 8];
      end
    end else begin
      e.d = ref_mem[i];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 0; we = 0; addr = 0; wdata = 0; sel = 0; rsp_ready = 0;
    repeat (2) @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", rdata); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    obs.delete();
    step(1, 1, 32'd20, 32'hDEADBEEF, 4'hF, 1, acc);
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL wr_accept: got %b want 1", acc); end
    step(1, 0, 32'd20, 32'h0, 4'h0, 1, acc);
    step(0, 0, 32'd0, 32'h0, 4'h0, 1, acc);
    n_checks++; if (obs.size() !== 2) begin n_fail++; $display("FAIL wr_rd_count: got %0d want 2", obs.size()); end
    n_checks++; if (obs[0].d !== 32'h0 || obs[0].e !== 1'b0) begin n_fail++; $display("FAIL wr_rsp: got %h/%b want 0/0", obs[0].d, obs[0].e); end
    n_checks++; if (obs[1].d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", obs[1].d); end
    n_checks++; if (obs[1].e !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b want 0", obs[1].e); end
    n_checks++; if (obs[1].cyc !== obs[0].cyc + 1) begin n_fail++; $display("FAIL rd_latency: got cycle %0d want %0d", obs[1].cyc, obs[0].cyc + 1); end
  endtask

  task automatic test_byte_enable();
    obs.delete();
    step(1, 1, 32'd36, 32'h11223344, 4'hF, 1, acc);
    step(1, 1, 32'd36, 32'hAABBCCDD, 4'h5, 1, acc);
    step(1, 0, 32'd36, 32'h0, 4'h0, 1, acc);
    step(1, 1, 32'd36, 32'hFFFFFFFF, 4'h0, 1, acc);
    step(1, 0, 32'd36, 32'h0, 4'h0, 1, acc);
    step(0, 0, 32'd0, 32'h0, 4'h0, 1, acc);
    n_checks++; if (obs.size() !== 5) begin n_fail++; $display("FAIL be_count: got %0d want 5", obs.size()); end
    n_checks++; if (obs[2].d !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_merge: got %h want 11bb33dd", obs[2].d); end
    n_checks++; if (obs[3].e !== 1'b1 || obs[3].d !== 32'h0) begin n_fail++; $display("FAIL be_sel0_rsp: got %h/%b want 0/1", obs[3].d, obs[3].e); end
    n_checks++; if (obs[4].d !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_sel0_nowrite: got %h want 11bb33dd", obs[4].d); end
  endtask

  task automatic test_backpressure();
    obs.delete();
    step(1, 1, 32'd28, 32'hCAFEF00D, 4'hF, 1, acc);
    step(1, 0, 32'd28, 32'h0, 4'h0, 1, acc);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 32'd20, 32'h0, 4'h0, 0, acc);
      n_checks++; if (seen_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", k, seen_valid); end
      n_checks++; if (seen_data !== 32'hCAFEF00D || seen_err !== 1'b0) begin n_fail++; $display("FAIL bp_data[%0d]: got %h/%b want cafef00d/0", k, seen_data, seen_err); end
      n_checks++; if (seen_req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready[%0d]: got %b want 0", k, seen_req_ready); end
      n_checks++; if (acc !== 1'b0) begin n_fail++; $display("FAIL bp_accept[%0d]: got %b want 0", k, acc); end
    end
    step(1, 0, 32'd20, 32'h0, 4'h0, 1, acc);
    n_checks++; if (seen_data !== 32'hCAFEF00D || acc !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %h acc %b want cafef00d acc 1", seen_data, acc); end
    step(0, 0, 32'd0, 32'h0, 4'h0, 1, acc);
    n_checks++; if (obs.size() !== 3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", obs.size()); end
    n_checks++; if (obs[1].d !== 32'hCAFEF00D) begin n_fail++; $display("FAIL bp_rsp: got %h want cafef00d", obs[1].d); end
    n_checks++; if (obs[2].d !== 32'hDEADBEEF || obs[2].cyc !== obs[1].cyc + 1) begin n_fail++; $display("FAIL bp_next: got %h at %0d want deadbeef at %0d", obs[2].d, obs[2].cyc, obs[1].cyc + 1); end
  endtask

  task automatic test_out_of_range();
    obs.delete();
    step(1, 1, 32'(4 * (DP - 1)), 32'h0B0B0B0B, 4'hF, 1, acc);
    step(1, 0, 32'(4 * DP), 32'h0, 4'h0, 1, acc);
    step(1, 1, 32'(4 * DP + 1), 32'hFFFFFFFF, 4'hF, 1, acc);
    step(1, 0, 32'(4 * (DP - 1)), 32'h0, 4'h0, 1, acc);
    step(1, 0, 32'd23, 32'h0, 4'h0, 1, acc);
    step(1, 0, 32'hFFFFFFFC, 32'h0, 4'h0, 1, acc);
    step(0, 0, 32'd0, 32'h0, 4'h0, 1, acc);
    n_checks++; if (obs.size() !== 6) begin n_fail++; $display("FAIL oor_count: got %0d want 6", obs.size()); end
    n_checks++; if (obs[1].e !== 1'b1 || obs[1].d !== 32'h0) begin n_fail++; $display("FAIL oor_read: got %h/%b want 0/1", obs[1].d, obs[1].e); end
    n_checks++; if (obs[2].e !== 1'b1 || obs[2].d !== 32'h0) begin n_fail++; $display("FAIL oor_write: got %h/%b want 0/1", obs[2].d, obs[2].e); end
    n_checks++; if (obs[3].d !== 32'h0B0B0B0B || obs[3].e !== 1'b0) begin n_fail++; $display("FAIL last_idx: got %h/%b want 0b0b0b0b/0", obs[3].d, obs[3].e); end
    n_checks++; if (obs[4].d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL low_bits: got %h want deadbeef", obs[4].d); end
    n_checks++; if (obs[5].e !== 1'b1) begin n_fail++; $display("FAIL oor_high: got %b want 1", obs[5].e); end
  endtask

  task automatic test_back_to_back();
    int n_acc;
    logic [31:0] v;
    obs.delete();
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 32'(4 * i), 32'h1000_0000 + 32'(i) * 32'h0101_0101, 4'hF, 1, acc);
      n_acc += int'(acc);
    end
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 32'(4 * i), 32'h0, 4'h0, 1, acc);
      n_acc += int'(acc);
    end
    step(0, 0, 32'd0, 32'h0, 4'h0, 1, acc);
    n_checks++; if (n_acc !== 16) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 16", n_acc); end
    n_checks++; if (obs.size() !== 16) begin n_fail++; $display("FAIL b2b_count: got %0d want 16", obs.size()); end
    for (int i = 0; i < 8; i++) begin
      v = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      n_checks++;
      if (obs[8+i].d !== v || obs[8+i].e !== 1'b0 || obs[8+i].cyc !== obs[8].cyc + i) begin
        n_fail++;
        $display("FAIL b2b_read[%0d]: got %h/%b at %0d want %h/0 at %0d", i, obs[8+i].d, obs[8+i].e, obs[8+i].cyc, v, obs[8].cyc + i);
      end
    end
  endtask

  task automatic test_parity();
    logic [31:0] v;
    logic        exp_e;
    v = 32'h1000_0000 + 32'd3 * 32'h0101_0101;
`ifdef MEM_PARITY_EN
    exp_e = 1'b1;
`else
    exp_e = 1'b0;
`endif
    obs.delete();
    dut.mem[3][9] = ~dut.mem[3][9];
    step(1, 0, 32'd12, 32'h0, 4'h0, 1, acc);
    step(1, 0, 32'd16, 32'h0, 4'h0, 1, acc);
    step(1, 1, 32'd12, v, 4'hF, 1, acc);
    step(1, 0, 32'd12, 32'h0, 4'h0, 1, acc);
    step(0, 0, 32'd0, 32'h0, 4'h0, 1, acc);
    n_checks++; if (obs[0].d !== (v ^ 32'h0000_0200)) begin n_fail++; $display("FAIL par_raw_data: got %h want %h", obs[0].d, v ^ 32'h0000_0200); end
    n_checks++; if (obs[0].e !== exp_e) begin n_fail++; $display("FAIL par_err: got %b want %b", obs[0].e, exp_e); end
    n_checks++; if (obs[1].e !== 1'b0) begin n_fail++; $display("FAIL par_neighbor: got %b want 0", obs[1].e); end
    n_checks++; if (obs[3].d !== v || obs[3].e !== 1'b0) begin n_fail++; $display("FAIL par_rewrite: got %h/%b want %h/0", obs[3].d, obs[3].e, v); end
  endtask

  task automatic test_read_only();
    logic [31:0] old_v;
    logic [3:0]  p;
    old_v = 32'h0BADCAFE;
    for (int b = 0; b < 4; b++) p[b] = ^old_v[8*b +: 8];
    u_ro.mem[0] = old_v;
`ifdef MEM_PARITY_EN
    u_ro.par_mem[0] = p;
`else
    if (p === 4'hx) $display("parity preload skipped");
`endif
    obs.delete(); obs_ro.delete();
    step(1, 1, 32'd0, 32'h55555555, 4'hF, 1, acc);
    step(1, 0, 32'd0, 32'h0, 4'h0, 1, acc);
    step(0, 0, 32'd0, 32'h0, 4'h0, 1, acc);
    n_checks++; if (obs_ro.size() !== 2) begin n_fail++; $display("FAIL ro_count: got %0d want 2", obs_ro.size()); end
    n_checks++; if (obs_ro[0].e !== 1'b1 || obs_ro[0].d !== 32'h0) begin n_fail++; $display("FAIL ro_write: got %h/%b want 0/1", obs_ro[0].d, obs_ro[0].e); end
    n_checks++; if (obs_ro[1].d !== old_v || obs_ro[1].e !== 1'b0) begin n_fail++; $display("FAIL ro_read: got %h/%b want %h/0", obs_ro[1].d, obs_ro[1].e, old_v); end
    n_checks++; if (obs[1].d !== 32'h55555555) begin n_fail++; $display("FAIL rw_contrast: got %h want 55555555", obs[1].d); end
  endtask

  task automatic test_random();
    rsp_t e;
    logic v, w, r;
    logic [31:0] a, d;
    logic [3:0]  s;
    logic pending;
    obs.delete(); exp_q.delete();
    for (int i = 0; i < DP; i++) begin
      d = $urandom;
      step(1, 1, 32'(4 * i), d, 4'hF, 1, acc);
      ref_access(1'b1, 32'(4 * i), d, 4'hF, e);
      exp_q.push_back(e);
    end
    for (int k = 0; k < 400; k++) begin
      v = ($urandom_range(0, 3) != 0);
      w = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, (DP + 2) * 4 - 1));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 2) != 0);
      pending = (exp_q.size() > obs.size());
      step(v, w, a, d, s, r, acc);
      n_checks++; if (seen_valid !== pending) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", k, seen_valid, pending); end
      n_checks++; if (seen_req_ready !== (!pending || r)) begin n_fail++; $display("FAIL rnd_req_ready[%0d]: got %b want %b", k, seen_req_ready, !pending || r); end
      if (acc) begin
        ref_access(w, a, d, s, e);
        exp_q.push_back(e);
      end
    end
    repeat (3) step(0, 0, 32'd0, 32'h0, 4'h0, 1, acc);
    n_checks++; if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_checks++;
      if (obs[i].d !== exp_q[i].d || obs[i].e !== exp_q[i].e) begin
        n_fail++;
        $display("FAIL rnd_rsp[%0d]: got %h/%b want %h/%b", i, obs[i].d, obs[i].e, exp_q[i].d, exp_q[i].e);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs.delete();
    step(1, 1, 32'd8, 32'h5A5A5A5A, 4'hF, 0, acc);
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL rm_accept: got %b want 1", acc); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0 || rdata !== 32'h0) begin n_fail++; $display("FAIL rm_drop: got %b/%h want 0/0", rsp_valid, rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 32'd8, 32'h0, 4'h0, 1, acc);
    step(0, 0, 32'd0, 32'h0, 4'h0, 1, acc);
    n_checks++; if (obs.size() !== 1) begin n_fail++; $display("FAIL rm_count: got %0d want 1", obs.size()); end
    n_checks++; if (obs[0].d !== 32'h5A5A5A5A || obs[0].e !== 1'b0) begin n_fail++; $display("FAIL rm_write_kept: got %h/%b want 5a5a5a5a/0", obs[0].d, obs[0].e); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_backpressure();
    test_out_of_range();
    test_back_to_back();
    test_parity();
    test_read_only();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_sp_vr.md
Name: mem_sp_vr

Overview:
- Parametrised single-port on-chip memory peripheral with a valid/ready request/response handshake. It is the generalised successor of the fixed 32-bit boot ROM.
- Configurable data width, depth and read-only mode.
- Holds read data stable under response backpressure and flags out-of-range or illegal accesses on an error output.
- Sits on the core/bus interconnect as ROM or RAM slave.

Parameters:
- AW, 32, address width in bits (byte address).
- DW, 32, data width in bits; must be 32 or 64.
- DP, 4096, depth in words; any value 2..65536, need not be a power of 2.
- READ_ONLY, 0, 1 = all writes are rejected with an error response.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- addr_i  input  AW  byte address of the request
- data_i  input  DW  write data
- sel_i  input  DW/8  byte enables for writes
- we_i  input  1  1 = write, 0 = read
- req_valid_i  input  1  request valid
- req_ready_o  output  1  request accepted when valid and ready are both high
- data_o  output  DW  response read data
- err_o  output  1  response error flag, qualified by rsp_valid_o
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  response consumed when valid and ready are both high

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: rsp_valid_o=0, err_o=0, data_o=0, state=IDLE. Memory contents are not reset.
- Word index: idx = addr_i[AW-1:log2(DW/8)]. Low address bits are ignored.
- Acceptance: req_ready_o = !rsp_valid_o || rsp_ready_i. This is combinational and has no dependence on req_valid_i.
- Throughput: one request per cycle when rsp_ready_i is held high.
- Latency: the response is valid in the cycle after acceptance (1-cycle synchronous array).
- Read: data_o = mem[idx]; err_o=0.
- Write (we_i=1, in range, READ_ONLY=0):
  - Bytes with sel_i[b]=1 are written at the accept edge; all other bytes are unchanged.
  - Response has data_o=0, err_o=1 if sel_i==0, else err_o=0.
- Out of range (idx >= DP): no array access; response data_o=0, err_o=1.
- READ_ONLY=1 and we_i=1: no write; response data_o=0, err_o=1. Reads behave normally.
- Response FSM:
  - IDLE: no response pending. Accept goes to NEW.
  - NEW: data_o is driven from the array output.
    - rsp_ready_i=1 with a new accept: stay NEW.
    - rsp_ready_i=1 without an accept: go to IDLE.
    - rsp_ready_i=0: capture the array output into the hold register and go to HOLD.
  - HOLD: data_o is driven from the hold register.
    - rsp_ready_i=1 with accept: go to NEW.
    - rsp_ready_i=1 without accept: go to IDLE.
    - Otherwise stay HOLD.
  - The array read port must not be re-addressed while a response is stalled.
- Stability: data_o, err_o and rsp_valid_o are stable from assertion until the handshake completes.
- Read-after-write: a read accepted the cycle after a write to the same idx returns the new data.
- Reset mid-operation: a pending response is dropped and no response is issued. A write already accepted before reset assertion remains in the array.
- Synthesis guard: DW not 32/64 or DP > 2^(AW-log2(DW/8)) is a parameter error, reported by $error at elaboration.

Optional Feature:
- Macro: MEM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte and computed for each written byte.
  - On read, any byte parity mismatch sets err_o=1; data_o still returns the raw stored data.
  - Write-response error rules are unchanged.
- Undefined: no parity storage or logic; err_o reflects only range, read-only and sel rules.

Test Plan:
- Write idx 5 = 0xDEADBEEF with sel=0xF, then read idx 5 -> response next cycle, data_o=0xDEADBEEF, err_o=0.
- Write 0x11223344 full, then write 0xAABBCCDD with sel=0x5, then read -> data_o=0x11BB33DD.
- Read idx 7 (preloaded 0xCAFEF00D) with rsp_ready_i=0 for 3 cycles:
  - rsp_valid_o=1 and data_o=0xCAFEF00D held constant.
  - req_ready_o=0 throughout.
  - A single handshake completes when ready rises.
- Read at idx=DP -> err_o=1, data_o=0. Separately, READ_ONLY=1 write to idx 0 -> err_o=1 and a subsequent read returns the old value.
- 8 back-to-back reads with rsp_ready_i=1 -> 8 responses in 8 consecutive cycles, in order, with correct data.
- MEM_PARITY_EN: backdoor-flip bit 9 of idx 3, then read -> err_o=1, data_o shows the flipped bit. Without the macro, the same flip gives err_o=0.
